// File: rtl/rvfi_chk_pkg.sv
// ----------------------------------------------------------------------------
// rvfi_chk_pkg
// Shared definitions for the RVFI data-memory serializer.
//   ORDER_W      width of the RVFI retirement order tag carried per entry
//   XLEN/MASK_W  data/address width and byte-mask width of one entry
//   mem_entry_t  one queued memory transaction
//   ser_state_e  serializer control states
//   order_after  true when a new order tag lies 1..127 steps after the last
// ----------------------------------------------------------------------------
package rvfi_chk_pkg;

    localparam int ORDER_W = 8;
    localparam int XLEN    = 32;
    localparam int MASK_W  = XLEN / 8;

    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic [XLEN-1:0]    addr;
        logic [MASK_W-1:0]  rmask;
        logic [MASK_W-1:0]  wmask;
        logic [XLEN-1:0]    rdata;
        logic [XLEN-1:0]    wdata;
    } mem_entry_t;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } ser_state_e;

    // The order tag wraps at 256, so "later" means the modular distance from
    // the previous tag is in the forward half-window 1..127.
    function automatic logic order_after(input logic [ORDER_W-1:0] new_ord,
                                         input logic [ORDER_W-1:0] last_ord);
        logic [ORDER_W-1:0] diff;
        diff = new_ord - last_ord;
        return (diff != '0) && !diff[ORDER_W-1];
    endfunction

endpackage

// File: rtl/rvfi_dmem_serializer_if.sv
// ----------------------------------------------------------------------------
// rvfi_dmem_serializer_if
// Bundles the multi-channel RVFI memory inputs, the single-entry output
// stream and the status flags of the serializer.
//   rvfi_*      NRET retire channels, flattened per channel (core side)
//   out_*       head entry of the queue with a valid/ready handshake
//   count       occupied queue entries
//   overflow    sticky, a bundle was dropped
//   order_err   sticky, a non-increasing order tag was pushed
//   halted      serializer stopped accepting after an overflow
// Modports: slave = the serializer, master = core/checker side.
// ----------------------------------------------------------------------------
interface rvfi_dmem_serializer_if
    import rvfi_chk_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NRET-1:0]         rvfi_valid;
    logic [NRET*ORDER_W-1:0] rvfi_order;
    logic [NRET*XLEN-1:0]    rvfi_mem_addr;
    logic [NRET*MASK_W-1:0]  rvfi_mem_rmask;
    logic [NRET*MASK_W-1:0]  rvfi_mem_wmask;
    logic [NRET*XLEN-1:0]    rvfi_mem_rdata;
    logic [NRET*XLEN-1:0]    rvfi_mem_wdata;

    logic                    out_valid;
    logic                    out_ready;
    logic [ORDER_W-1:0]      out_order;
    logic [XLEN-1:0]         out_addr;
    logic [MASK_W-1:0]       out_rmask;
    logic [MASK_W-1:0]       out_wmask;
    logic [XLEN-1:0]         out_rdata;
    logic [XLEN-1:0]         out_wdata;

    logic [CNT_W-1:0]        count;
    logic                    overflow;
    logic                    order_err;
    logic                    halted;

    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_mem_addr, rvfi_mem_rmask,
               rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata, out_ready,
        output out_valid, out_order, out_addr, out_rmask, out_wmask,
               out_rdata, out_wdata, count, overflow, order_err, halted
    );

    modport master (
        output rvfi_valid, rvfi_order, rvfi_mem_addr, rvfi_mem_rmask,
               rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata, out_ready,
        input  out_valid, out_order, out_addr, out_rmask, out_wmask,
               out_rdata, out_wdata, count, overflow, order_err, halted
    );

endinterface

// File: rtl/rvfi_mq_ram.sv
// ----------------------------------------------------------------------------
// rvfi_mq_ram
// DEPTH-entry register array with NRET independent write ports and one
// asynchronous read port. Storage is not reset; validity is tracked by the
// owner's count.
//   clk       clock
//   we_i      per-port write enable
//   waddr_i   per-port write index
//   wdata_i   per-port entry to store
//   raddr_i   read index
//   rdata_o   entry at raddr_i (combinational)
// ----------------------------------------------------------------------------
module rvfi_mq_ram
    import rvfi_chk_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NRET  = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic [NRET-1:0]            we_i,
    input  logic [NRET-1:0][PTR_W-1:0] waddr_i,
    input  mem_entry_t [NRET-1:0]      wdata_i,
    input  logic [PTR_W-1:0]           raddr_i,
    output mem_entry_t                 rdata_o
);

    mem_entry_t mem_q [DEPTH];

    // The owner guarantees that enabled ports target distinct slots.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NRET; p++) begin
            if (we_i[p]) begin
                mem_q[waddr_i[p]] <= wdata_i[p];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rvfi_dmem_serializer.sv
// ----------------------------------------------------------------------------
// rvfi_dmem_serializer
// Queues memory transactions retired on up to NRET RVFI channels per cycle in
// retirement order and replays them one per cycle on a valid/ready stream.
// An overflowing bundle is dropped whole and halts further intake; order tags
// that fail to advance raise a sticky error.
//   clk    clock, all logic on posedge
//   reset  asynchronous, active-high
//   bus    rvfi_dmem_serializer_if.slave (RVFI inputs, out stream, status)
// ----------------------------------------------------------------------------
module rvfi_dmem_serializer
    import rvfi_chk_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input logic                   clk,
    input logic                   reset,
    rvfi_dmem_serializer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    ser_state_e                 state_q, state_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       overflow_q, overflow_d;
    logic                       order_err_q, order_err_d;
    logic                       last_valid_q, last_valid_d;
    logic [ORDER_W-1:0]         last_order_q, last_order_d;

    mem_entry_t [NRET-1:0]      chan_entry;
    logic [NRET-1:0]            is_op;
    logic [NRET-1:0]            we;
    logic [NRET-1:0][PTR_W-1:0] waddr;
    logic [CNT_W-1:0]           pushes;
    logic [CNT_W-1:0]           free_slots;
    logic                       pop;
    logic                       accept;
    logic                       drop;
    mem_entry_t                 head;

    // Slice the flattened RVFI buses into one entry per channel; a channel is
    // a memory op only when it retires and touches at least one byte.
    always_comb begin
        for (int c = 0; c < NRET; c++) begin
            chan_entry[c].order = bus.rvfi_order[c*ORDER_W +: ORDER_W];
            chan_entry[c].addr  = bus.rvfi_mem_addr[c*XLEN +: XLEN];
            chan_entry[c].rmask = bus.rvfi_mem_rmask[c*MASK_W +: MASK_W];
            chan_entry[c].wmask = bus.rvfi_mem_wmask[c*MASK_W +: MASK_W];
            chan_entry[c].rdata = bus.rvfi_mem_rdata[c*XLEN +: XLEN];
            chan_entry[c].wdata = bus.rvfi_mem_wdata[c*XLEN +: XLEN];
            is_op[c] = bus.rvfi_valid[c] &&
                       ((chan_entry[c].rmask | chan_entry[c].wmask) != '0);
        end
    end

    // Each op lands at wr_ptr plus the number of ops on lower channels, which
    // packs the bundle contiguously in ascending channel order.
    always_comb begin
        pushes = '0;
        for (int c = 0; c < NRET; c++) begin
            waddr[c] = wr_ptr_q + pushes[PTR_W-1:0];
            pushes   = pushes + CNT_W'(is_op[c]);
        end
    end

    // Space accounting credits this cycle's pop, so a full queue being drained
    // can still take one new entry. A bundle is accepted whole or not at all.
    assign pop        = (count_q != '0) && bus.out_ready;
    assign free_slots = DEPTH_C - count_q + CNT_W'(pop);
    assign accept     = (state_q == ST_RUN) && (pushes != '0) && (pushes <= free_slots);
    assign drop       = (state_q == ST_RUN) && (pushes > free_slots);
    assign we         = accept ? is_op : '0;

    // Next-state for pointers, occupancy, sticky flags and the RUN/HALT FSM.
    // The order check walks accepted ops in channel order so that a later
    // channel is compared against an earlier one pushed in the same cycle.
    always_comb begin
        logic [ORDER_W-1:0] prev_order;
        logic               prev_valid;

        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        count_d      = count_q - CNT_W'(pop);
        overflow_d   = overflow_q;
        order_err_d  = order_err_q;
        prev_order   = last_order_q;
        prev_valid   = last_valid_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + pushes[PTR_W-1:0];
            count_d  = count_q + pushes - CNT_W'(pop);
        end

        for (int c = 0; c < NRET; c++) begin
            if (we[c]) begin
                if (prev_valid && !order_after(chan_entry[c].order, prev_order)) begin
                    order_err_d = 1'b1;
                end
                prev_order = chan_entry[c].order;
                prev_valid = 1'b1;
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
            state_d    = ST_HALT;
        end

        last_order_d = prev_order;
        last_valid_d = prev_valid;
    end

    // State registers; reset discards the queue at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            order_err_q  <= 1'b0;
            last_valid_q <= 1'b0;
            last_order_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            order_err_q  <= order_err_d;
            last_valid_q <= last_valid_d;
            last_order_q <= last_order_d;
        end
    end

    rvfi_mq_ram #(
        .DEPTH (DEPTH),
        .NRET  (NRET)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (chan_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign bus.out_valid = (count_q != '0);
    assign bus.out_order = head.order;
    assign bus.out_addr  = head.addr;
    assign bus.out_rmask = head.rmask;
    assign bus.out_wmask = head.wmask;
    assign bus.out_rdata = head.rdata;
    assign bus.out_wdata = head.wdata;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.order_err = order_err_q;
    assign bus.halted    = (state_q == ST_HALT);

endmodule

// File: doc/rvfi_dmem_serializer.md
Name: rvfi_dmem_serializer

Overview:
- Collects memory transactions retired on up to NRET RVFI channels per cycle and queues them in retirement order.
- Replays them one per cycle over a valid/ready stream, so a single-channel shadow-memory checker can serve a multi-retire core.
- Sits between the core's RVFI bus and the data-memory consistency checker.
- Flags overflow and order violations as sticky error bits for formal asserts or cover.

Parameters:
- XLEN, 32, data/address width.
- NRET, 2, RVFI channels per cycle.
- DEPTH, 8, queue entries, power of two, DEPTH >= NRET.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- rvfi_valid  in  NRET  channel retire valid.
- rvfi_order  in  NRET*8  retirement order per channel.
- rvfi_mem_addr  in  NRET*XLEN  memory address.
- rvfi_mem_rmask  in  NRET*XLEN/8  read byte mask.
- rvfi_mem_wmask  in  NRET*XLEN/8  write byte mask.
- rvfi_mem_rdata  in  NRET*XLEN  read data.
- rvfi_mem_wdata  in  NRET*XLEN  write data.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_order  out  8  head order.
- out_addr  out  XLEN  head address.
- out_rmask  out  XLEN/8  head read mask.
- out_wmask  out  XLEN/8  head write mask.
- out_rdata  out  XLEN  head read data.
- out_wdata  out  XLEN  head write data.
- count  out  $clog2(DEPTH)+1  occupied entries.
- overflow  out  1  sticky: a bundle was dropped.
- order_err  out  1  sticky: non-increasing order seen.
- halted  out  1  FSM is in HALT.

Behaviour:
- Reset (async assert): count=0, rd/wr pointers=0, out_valid=0, overflow=0, order_err=0, halted=0, FSM=RUN, last_order valid bit cleared.
- Out data ports read the head entry combinationally; their value is don't-care while out_valid=0.
- Memory op: channel c with rvfi_valid[c] and (rmask|wmask)!=0. Other valid channels are ignored.
- Push ordering: memory ops in a cycle are pushed in ascending channel index, packed contiguously at wr_ptr. Entries take 0 to NRET writes per cycle.
- Pop: when out_valid && out_ready, rd_ptr advances by 1. There is exactly one pop per cycle at most.
- Latency: an op retired in cycle N appears at the head no earlier than cycle N+1 (registered queue, no bypass).
- Simultaneous push and pop: count_next = count + pushes - pop.
  - Space check uses the current-cycle pop: free = DEPTH - count + pop.
- Full: if pushes > free, the whole bundle is dropped (no partial push). overflow is set next cycle and FSM goes to HALT.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- Order check: each pushed entry compares against last_order (the previous pushed entry, including earlier channels in the same cycle).
  - Error if (new - last) mod 256 is not in 1..127; this sets order_err.
  - No check on the first push after reset.
  - last_order is updated on every push.
- FSM:
  - RUN: accept pushes; overflow goes to HALT.
  - HALT: ignore all inputs; keep draining queued entries to out; halted=1.
  - HALT is left only by reset.
- order_err does not halt.
- Reset mid-drain: queue contents are discarded immediately and out_valid drops asynchronously.

Decomposition:
- Shared package rvfi_chk_pkg holds:
  - ORDER_W=8.
  - Memory entry struct {order, addr, rmask, wmask, rdata, wdata} parameterised by XLEN.
  - Function order_after(new, last) implementing the mod-256 window.
- Natural sub-module: rvfi_mq_ram, a DEPTH-entry multi-write (NRET ports), single-read register array with async read. Pointer, count, FSM and checks stay in the top.

Test Plan:
- NRET=2, DEPTH=8: cycle 0 ch0 store addr 0x100 wmask 0xF order 5, ch1 load addr 0x104 rmask 0x3 order 6, out_ready=1.
  - Expect 0x100/order 5 at cycle 1 and 0x104/order 6 at cycle 2; count 2→1→0.
- ch0 valid with masks 0, ch1 store order 9 → exactly one entry, order 9, count=1.
- out_ready=0; 4 cycles of dual stores fill to 8; 5th dual store → dropped, overflow=1, halted=1, count=8.
  - Then out_ready=1 drains all 8 in order; later inputs are ignored.
- count=8, out_ready=1, same cycle single store → free=1, accepted; count stays 8. Dual store in that case → dropped, overflow=1.
- Order wrap: pushes with order 254, 255, 0, 1 → order_err=0. Next push order 1 → order_err=1. Same-cycle ch0=7, ch1=7 → order_err=1.
- Assert reset while out_valid=1 and count=3 → out_valid=0 and count=0 immediately.
  - After deassert, the first push order 200 does not set order_err.
